regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined datapath.
- Provides two combinational read ports, one writeback port with write-through bypass, and an optional hardwired zero register.
- Includes a per-register pending-write scoreboard that flags RAW and WAW hazards to the issue stage.
- Sits between decode/issue (reads, hazard check, destination reservation) and writeback (data commit, reservation release).

Parameters:
- XLEN, 64, data width of each register.
- AW, 5, address width; register count NREG = 2**AW.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, and is never marked pending.
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_use  in  1  port 1 operand is consumed by the issuing instruction.
- rs2_use  in  1  port 2 operand is consumed by the issuing instruction.
- rd1_data  out  XLEN  read port 1 data.
- rd2_data  out  XLEN  read port 2 data.
- iss_valid  in  1  an instruction issues this cycle; reserve iss_rd.
- iss_rd  in  AW  destination register being reserved.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- raw_hazard  out  1  an operand in use is pending.
- waw_hazard  out  1  the issue destination is already pending.
- pend_count  out  AW+1  number of registers currently pending.

Behaviour:
- Reset (async, level): all registers cleared to 0, all pending bits cleared, pend_count = 0. Read outputs then show 0 combinationally. Reset asserted mid-operation discards any in-flight issue or writeback in that cycle.
- Write: on posedge clk, if wb_valid then reg[wb_rd] <= wb_data. The write happens whether or not wb_rd is pending. With ZERO_REG=1, writes to address 0 are dropped.
- Read, per port, combinational, in priority order:
  - ZERO_REG and addr==0 -> 0.
  - else BYPASS and wb_valid and wb_rd==addr -> wb_data.
  - else reg[addr].
- With BYPASS=0, a same-cycle write becomes visible the cycle after the edge.
- Pending bits, updated on posedge clk:
  - set_en = iss_valid and not (ZERO_REG and iss_rd==0).
  - clr_en = wb_valid.
  - pend[wb_rd] cleared if clr_en; pend[iss_rd] set if set_en.
  - When iss_rd==wb_rd in the same cycle, the set wins: the new producer owns the register.
- rsX_pend = pend[rsX_addr], except:
  - forced 0 when ZERO_REG and addr==0;
  - forced 0 when BYPASS and wb_valid and wb_rd==rsX_addr (the data is being forwarded).
- raw_hazard = (rs1_use and rs1_pend) or (rs2_use and rs2_pend); combinational.
- waw_hazard = iss_valid and pend[iss_rd] and not (wb_valid and wb_rd==iss_rd); forced 0 for register 0 when ZERO_REG.
- The block does not block an issue; the issue stage must not assert iss_valid while raw_hazard or waw_hazard is high. If it does, the bits still update per the rules above.
- pend_count is a registered counter. Per edge:
  - next = count + inc - dec;
  - inc = set_en and target not already pending (or being cleared this cycle);
  - dec = clr_en and pend[wb_rd]==1 and not being re-set this cycle.
  - A writeback to a non-pending register gives no decrement.
  - Invariant: pend_count equals the popcount of the pending vector at all times; the counter never wraps.

Test Plan:
- Reset released, read addresses 0..31 -> all data 0, raw_hazard=0, pend_count=0. Assert reset mid-stream after 3 issues -> pend_count returns to 0 immediately, asynchronously.
- Issue rd=5, next cycle read rs1=5 with rs1_use=1 -> raw_hazard=1, pend_count=1. Writeback rd=5 data 0xDEAD_BEEF with rs1=5 in the same cycle -> rd1_data=0xDEADBEEF, raw_hazard=0 (BYPASS=1); next cycle pend_count=0.
- ZERO_REG=1: write 0x1234 to x0, issue rd=0 -> rd1_data for rs1=0 reads 0, pend_count stays 0, waw_hazard=0.
- Simultaneous issue rd=7 and writeback rd=7 while x7 is pending -> pend[7] remains set, pend_count unchanged, reg7 takes the wb_data.
- Issue to x9 while x9 is pending with no writeback -> waw_hazard=1. Issue all 31 non-zero registers -> pend_count=31. Retire all of them -> pend_count=0.
- BYPASS=0 build: writeback 0xAA to x3 while reading rs2=3 -> rd2_data shows the old value; the next cycle shows 0xAA.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Issue/read/writeback bundle between the pipeline and the scoreboarded register file.
interface regfile_sb_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_use;
    logic            rs2_use;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            raw_hazard;
    logic            waw_hazard;
    logic [AW:0]     pend_count;

    modport master (
        output rs1_addr, rs2_addr, rs1_use, rs2_use,
        output iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
        input  rd1_data, rd2_data, raw_hazard, waw_hazard, pend_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, rs1_use, rs2_use,
        input  iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
        output rd1_data, rd2_data, raw_hazard, waw_hazard, pend_count
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two read ports, bypassed writeback and a
// pending-write scoreboard reporting RAW/WAW hazards to issue.
module regfile_sb #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);
    localparam int unsigned NREG = 2 ** AW;
    localparam int unsigned CW   = AW + 1;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [CW-1:0]   count;

    logic set_en, clr_en, wr_en, same_rd, inc, dec;
    logic rs1_zero, rs2_zero, rs1_byp, rs2_byp, rs1_pend, rs2_pend;

    // Scoreboard control; a same-register issue and writeback leaves the bit owned by the new producer
    always_comb begin
        same_rd = (bus.iss_rd == bus.wb_rd);
        set_en  = bus.iss_valid && !(ZERO_REG && (bus.iss_rd == '0));
        clr_en  = bus.wb_valid;
        wr_en   = bus.wb_valid && !(ZERO_REG && (bus.wb_rd == '0));
        inc     = set_en && !pend[bus.iss_rd];
        dec     = clr_en && pend[bus.wb_rd] && !(set_en && same_rd);

        pend_nxt = pend;
        if (clr_en) pend_nxt[bus.wb_rd] = 1'b0;
        if (set_en) pend_nxt[bus.iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= '0;
            count <= '0;
        end else begin
            pend  <= pend_nxt;
            count <= count + CW'(inc) - CW'(dec);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Read ports and hazard flags; forwarding is suppressed while reset discards the writeback
    always_comb begin
        rs1_zero = ZERO_REG && (bus.rs1_addr == '0);
        rs2_zero = ZERO_REG && (bus.rs2_addr == '0);
        rs1_byp  = BYPASS && !reset && bus.wb_valid && (bus.wb_rd == bus.rs1_addr);
        rs2_byp  = BYPASS && !reset && bus.wb_valid && (bus.wb_rd == bus.rs2_addr);

        bus.rd1_data = regs[bus.rs1_addr];
        if (rs1_zero)     bus.rd1_data = '0;
        else if (rs1_byp) bus.rd1_data = bus.wb_data;

        bus.rd2_data = regs[bus.rs2_addr];
        if (rs2_zero)     bus.rd2_data = '0;
        else if (rs2_byp) bus.rd2_data = bus.wb_data;

        rs1_pend = pend[bus.rs1_addr] && !rs1_zero && !rs1_byp;
        rs2_pend = pend[bus.rs2_addr] && !rs2_zero && !rs2_byp;

        bus.raw_hazard = (bus.rs1_use && rs1_pend) || (bus.rs2_use && rs2_pend);
        bus.waw_hazard = bus.iss_valid && pend[bus.iss_rd]
                         && !(bus.wb_valid && same_rd)
                         && !(ZERO_REG && (bus.iss_rd == '0));
        bus.pend_count = count;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: a bypassed and a non-bypassed instance driven in lockstep
// and compared against an array/popcount model of the register file.
module tb_regfile_sb;
    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = AW + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0]   rs1_addr, rs2_addr, iss_rd, wb_rd;
    logic            rs1_use, rs2_use, iss_valid, wb_valid;
    logic [XLEN-1:0] wb_data;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_a ();
    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_b ();

    assign bus_a.rs1_addr = rs1_addr;   assign bus_b.rs1_addr = rs1_addr;
    assign bus_a.rs2_addr = rs2_addr;   assign bus_b.rs2_addr = rs2_addr;
    assign bus_a.rs1_use  = rs1_use;    assign bus_b.rs1_use  = rs1_use;
    assign bus_a.rs2_use  = rs2_use;    assign bus_b.rs2_use  = rs2_use;
    assign bus_a.iss_valid = iss_valid; assign bus_b.iss_valid = iss_valid;
    assign bus_a.iss_rd   = iss_rd;     assign bus_b.iss_rd   = iss_rd;
    assign bus_a.wb_valid = wb_valid;   assign bus_b.wb_valid = wb_valid;
    assign bus_a.wb_rd    = wb_rd;      assign bus_b.wb_rd    = wb_rd;
    assign bus_a.wb_data  = wb_data;    assign bus_b.wb_data  = wb_data;

    regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && wb_valid && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit op_pending(input logic [AW-1:0] a, input bit byp);
        return (a != 0) && m_pend[a] && !(byp && wb_valid && wb_rd == a);
    endfunction

    function automatic bit exp_raw(input bit byp);
        return (rs1_use && op_pending(rs1_addr, byp)) || (rs2_use && op_pending(rs2_addr, byp));
    endfunction

    function automatic bit exp_waw();
        return iss_valid && (iss_rd != 0) && m_pend[iss_rd] && !(wb_valid && wb_rd == iss_rd);
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) if (m_pend[i]) n++;
        return CW'(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_commit();
        if (wb_valid) begin
            if (wb_rd != 0) m_regs[wb_rd] = wb_data;
            m_pend[wb_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    endtask

    task automatic idle();
        rs1_addr = '0; rs2_addr = '0; rs1_use = 1'b0; rs2_use = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    // Inputs change at negedge; the model advances with the same inputs the DUT samples
    task automatic tick();
        if (!reset) model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int a = 0; a < NREG; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(a); rs1_use = 1'b1; rs2_use = 1'b1;
            #1;
            if (bus_a.rd1_data !== '0 || bus_a.rd2_data !== '0 || bus_a.raw_hazard !== 1'b0) begin
                $display("FAIL reset_read x%0d: rd1=%h rd2=%h raw=%b want 0/0/0",
                         a, bus_a.rd1_data, bus_a.rd2_data, bus_a.raw_hazard);
                n_err++;
            end
            n_cmp++;
            tick();
        end
        if (bus_a.pend_count !== CW'(0)) begin
            $display("FAIL reset_count: got %0d want 0", bus_a.pend_count); n_err++;
        end
        n_cmp++;
        idle();
        for (int i = 1; i <= 3; i++) begin
            iss_valid = 1'b1; iss_rd = AW'(i);
            tick();
        end
        idle();
        #1;
        if (bus_a.pend_count !== CW'(3)) begin
            $display("FAIL pre_reset_count: got %0d want 3", bus_a.pend_count); n_err++;
        end
        n_cmp++;
        iss_valid = 1'b1; iss_rd = AW'(10);
        wb_valid = 1'b1; wb_rd = AW'(4); wb_data = 64'hFF;
        #2 reset = 1'b1;
        #1;
        if (bus_a.pend_count !== CW'(0)) begin
            $display("FAIL async_reset_count: got %0d want 0", bus_a.pend_count); n_err++;
        end
        n_cmp++;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        rs1_addr = AW'(4); iss_rd = AW'(10); iss_valid = 1'b1;
        #1;
        if (bus_a.rd1_data !== '0 || bus_a.waw_hazard !== 1'b0 || bus_a.pend_count !== CW'(0)) begin
            $display("FAIL reset_discard: rd1=%h waw=%b cnt=%0d want 0/0/0",
                     bus_a.rd1_data, bus_a.waw_hazard, bus_a.pend_count);
            n_err++;
        end
        n_cmp++;
        idle();
    endtask

    task automatic test_raw_bypass();
        iss_valid = 1'b1; iss_rd = AW'(5);
        tick();
        idle();
        rs1_addr = AW'(5); rs1_use = 1'b1;
        #1;
        if (bus_a.raw_hazard !== 1'b1 || bus_a.pend_count !== CW'(1)) begin
            $display("FAIL raw_pending: raw=%b cnt=%0d want 1/1", bus_a.raw_hazard, bus_a.pend_count);
            n_err++;
        end
        n_cmp++;
        wb_valid = 1'b1; wb_rd = AW'(5); wb_data = 64'hDEAD_BEEF;
        #1;
        if (bus_a.rd1_data !== 64'hDEAD_BEEF || bus_a.raw_hazard !== 1'b0) begin
            $display("FAIL raw_bypass: rd1=%h raw=%b want deadbeef/0", bus_a.rd1_data, bus_a.raw_hazard);
            n_err++;
        end
        n_cmp++;
        tick();
        idle();
        rs1_addr = AW'(5);
        #1;
        if (bus_a.pend_count !== CW'(0) || bus_a.rd1_data !== 64'hDEAD_BEEF) begin
            $display("FAIL raw_retire: cnt=%0d rd1=%h want 0/deadbeef", bus_a.pend_count, bus_a.rd1_data);
            n_err++;
        end
        n_cmp++;
        idle();
    endtask

    task automatic test_zero_reg();
        wb_valid = 1'b1; wb_rd = '0; wb_data = 64'h1234;
        iss_valid = 1'b1; iss_rd = '0; rs1_addr = '0; rs1_use = 1'b1;
        #1;
        if (bus_a.rd1_data !== '0 || bus_a.waw_hazard !== 1'b0 || bus_a.raw_hazard !== 1'b0) begin
            $display("FAIL zero_same_cycle: rd1=%h waw=%b raw=%b want 0/0/0",
                     bus_a.rd1_data, bus_a.waw_hazard, bus_a.raw_hazard);
            n_err++;
        end
        n_cmp++;
        tick();
        wb_valid = 1'b0;
        #1;
        if (bus_a.rd1_data !== '0 || bus_b.rd1_data !== '0 || bus_a.pend_count !== CW'(0)
            || bus_a.waw_hazard !== 1'b0) begin
            $display("FAIL zero_after: rd1a=%h rd1b=%h cnt=%0d waw=%b want 0/0/0/0",
                     bus_a.rd1_data, bus_b.rd1_data, bus_a.pend_count, bus_a.waw_hazard);
            n_err++;
        end
        n_cmp++;
        tick();
        idle();
    endtask

    task automatic test_same_rd();
        iss_valid = 1'b1; iss_rd = AW'(7);
        tick();
        wb_valid = 1'b1; wb_rd = AW'(7); wb_data = 64'h7777_0000_CAFE;
        #1;
        if (bus_a.waw_hazard !== 1'b0) begin
            $display("FAIL same_rd_waw: got %b want 0", bus_a.waw_hazard); n_err++;
        end
        n_cmp++;
        tick();
        idle();
        rs1_addr = AW'(7); rs1_use = 1'b1;
        #1;
        if (bus_a.pend_count !== CW'(1) || bus_a.raw_hazard !== 1'b1
            || bus_a.rd1_data !== 64'h7777_0000_CAFE) begin
            $display("FAIL same_rd_owner: cnt=%0d raw=%b rd1=%h want 1/1/77770000cafe",
                     bus_a.pend_count, bus_a.raw_hazard, bus_a.rd1_data);
            n_err++;
        end
        n_cmp++;
        idle();
        wb_valid = 1'b1; wb_rd = AW'(7); wb_data = 64'h7;
        tick();
        idle();
    endtask

    task automatic test_waw_fill();
        iss_valid = 1'b1; iss_rd = AW'(9);
        tick();
        #1;
        if (bus_a.waw_hazard !== 1'b1) begin
            $display("FAIL waw_set: got %b want 1", bus_a.waw_hazard); n_err++;
        end
        n_cmp++;
        tick();
        for (int i = 1; i < NREG; i++) begin
            iss_valid = 1'b1; iss_rd = AW'(i);
            tick();
        end
        idle();
        #1;
        if (bus_a.pend_count !== CW'(31)) begin
            $display("FAIL fill_count: got %0d want 31", bus_a.pend_count); n_err++;
        end
        n_cmp++;
        for (int i = 1; i < NREG; i++) begin
            wb_valid = 1'b1; wb_rd = AW'(i); wb_data = {$urandom, $urandom};
            tick();
            if (bus_a.pend_count !== CW'(31 - i)) begin
                $display("FAIL drain_count step %0d: got %0d want %0d", i, bus_a.pend_count, 31 - i);
                n_err++;
            end
            n_cmp++;
        end
        idle();
        wb_valid = 1'b1; wb_rd = AW'(12); wb_data = 64'h5;
        tick();
        idle();
        #1;
        if (bus_a.pend_count !== CW'(0)) begin
            $display("FAIL idle_wb_count: got %0d want 0", bus_a.pend_count); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_no_bypass();
        wb_valid = 1'b1; wb_rd = AW'(3); wb_data = 64'h55;
        tick();
        wb_data = 64'hAA; rs2_addr = AW'(3);
        #1;
        if (bus_b.rd2_data !== 64'h55 || bus_a.rd2_data !== 64'hAA) begin
            $display("FAIL nobyp_same_cycle: rd2b=%h rd2a=%h want 55/aa", bus_b.rd2_data, bus_a.rd2_data);
            n_err++;
        end
        n_cmp++;
        tick();
        wb_valid = 1'b0;
        #1;
        if (bus_b.rd2_data !== 64'hAA) begin
            $display("FAIL nobyp_next_cycle: rd2b=%h want aa", bus_b.rd2_data); n_err++;
        end
        n_cmp++;
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rs1_addr  = AW'($urandom_range(0, 31));
            rs2_addr  = AW'($urandom_range(0, 31));
            rs1_use   = 1'($urandom_range(0, 1));
            rs2_use   = 1'($urandom_range(0, 1));
            iss_valid = ($urandom_range(0, 99) < 40);
            iss_rd    = AW'($urandom_range(0, 31));
            wb_valid  = ($urandom_range(0, 99) < 45);
            wb_rd     = ($urandom_range(0, 3) == 0) ? iss_rd : AW'($urandom_range(0, 31));
            wb_data   = {$urandom, $urandom};
            #1;
            if (bus_a.rd1_data !== exp_rd(rs1_addr, 1'b1) || bus_a.rd2_data !== exp_rd(rs2_addr, 1'b1)) begin
                $display("FAIL rand_read_byp cyc %0d: rd1=%h rd2=%h want %h %h", c,
                         bus_a.rd1_data, bus_a.rd2_data, exp_rd(rs1_addr, 1'b1), exp_rd(rs2_addr, 1'b1));
                n_err++;
            end
            n_cmp++;
            if (bus_b.rd1_data !== exp_rd(rs1_addr, 1'b0) || bus_b.rd2_data !== exp_rd(rs2_addr, 1'b0)) begin
                $display("FAIL rand_read_nobyp cyc %0d: rd1=%h rd2=%h want %h %h", c,
                         bus_b.rd1_data, bus_b.rd2_data, exp_rd(rs1_addr, 1'b0), exp_rd(rs2_addr, 1'b0));
                n_err++;
            end
            n_cmp++;
            if (bus_a.raw_hazard !== exp_raw(1'b1) || bus_b.raw_hazard !== exp_raw(1'b0)) begin
                $display("FAIL rand_raw cyc %0d: a=%b b=%b want %b %b", c,
                         bus_a.raw_hazard, bus_b.raw_hazard, exp_raw(1'b1), exp_raw(1'b0));
                n_err++;
            end
            n_cmp++;
            if (bus_a.waw_hazard !== exp_waw() || bus_b.waw_hazard !== exp_waw()) begin
                $display("FAIL rand_waw cyc %0d: a=%b b=%b want %b", c,
                         bus_a.waw_hazard, bus_b.waw_hazard, exp_waw());
                n_err++;
            end
            n_cmp++;
            tick();
            if (bus_a.pend_count !== exp_cnt() || bus_b.pend_count !== exp_cnt()) begin
                $display("FAIL rand_count cyc %0d: a=%0d b=%0d want %0d", c,
                         bus_a.pend_count, bus_b.pend_count, exp_cnt());
                n_err++;
            end
            n_cmp++;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_raw_bypass();
        test_zero_reg();
        test_same_rd();
        test_waw_fill();
        test_no_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
